// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

   localparam int unsigned WIDTH_DEFAULT = 32;
   localparam int unsigned PC_STEP       = 4;

   // One queued fetch: PC, instruction word and a precomputed misalignment flag.
   typedef struct packed {
      logic [WIDTH_DEFAULT-1:0] pc;
      logic [WIDTH_DEFAULT-1:0] instr;
      logic                     misaligned;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle. master = fetch/decode side, slave = the queue.
interface fetch_queue_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_pc;
   logic [WIDTH-1:0] in_instr;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_pc;
   logic [WIDTH-1:0] out_instr;
   logic [WIDTH-1:0] out_pc_plus4;
   logic             out_misaligned;
   logic [CW-1:0]    count;

   modport master (
      output in_valid, in_pc, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_pc_plus4, out_misaligned, count
   );

   modport slave (
      input  in_valid, in_pc, in_instr, flush, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_pc_plus4, out_misaligned, count
   );
endinterface

// File: rtl/fq_storage.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous read port.
module fq_storage
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  fq_entry_t     wdata_i,
   input  logic [AW-1:0] raddr_i,
   output fq_entry_t     rdata_o
);

   fq_entry_t mem_q [DEPTH];

   // Entry write; reset clears every slot so head outputs are never X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// Optional same-cycle empty-queue bypass is enabled by defining IFQ_BYPASS_EN.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT,
   parameter int unsigned DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   fetch_queue_if.slave q_io
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   fq_entry_t in_entry, rd_entry, head;
   logic      empty, bypass, push, pop, we;

   assign empty = (count_q == '0);

`ifdef IFQ_BYPASS_EN
   // Empty queue: present the incoming fetch directly to decode.
   assign bypass = empty && q_io.in_valid;
`else
   assign bypass = 1'b0;
`endif

   // Package struct is WIDTH_DEFAULT wide; casts adapt to the instance WIDTH.
   always_comb begin
      in_entry            = '0;
      in_entry.pc         = WIDTH_DEFAULT'(q_io.in_pc);
      in_entry.instr      = WIDTH_DEFAULT'(q_io.in_instr);
      in_entry.misaligned = |q_io.in_pc[1:0];
   end

   fq_storage #(
      .DEPTH (DEPTH)
   ) u_storage (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   // Handshake decode and head selection.
   always_comb begin
      q_io.in_ready  = (count_q != CW'(DEPTH));
      q_io.out_valid = bypass || !empty;
      head           = bypass ? in_entry : rd_entry;
      // A bypassed entry that decode takes this cycle is never stored.
      push           = q_io.in_valid && q_io.in_ready && !(bypass && q_io.out_ready);
      pop            = q_io.out_valid && q_io.out_ready && !bypass;
      we             = push && !q_io.flush;
   end

   assign q_io.out_pc         = WIDTH'(head.pc);
   assign q_io.out_instr      = WIDTH'(head.instr);
   assign q_io.out_misaligned = head.misaligned;
   assign q_io.out_pc_plus4   = q_io.out_pc + WIDTH'(PC_STEP);
   assign q_io.count          = count_q;

   // Pointer/count next state; flush overrides any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (q_io.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (WIDTH=32, DEPTH=4).
module tb_fetch_queue;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fetch_queue_if #(.WIDTH(32), .DEPTH(4)) q_if ();

   fetch_queue #(
      .WIDTH (32),
      .DEPTH (4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .q_io (q_if)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle.
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
      q_if.in_valid  = v;
      q_if.in_pc     = pc;
      q_if.in_instr  = 32'hA000_0000 ^ pc;
      q_if.out_ready = rdy;
      q_if.flush     = fl;
   endtask

   initial begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #2;
      // Reset state
      chk("rst_count", 32'(q_if.count), 32'd0);
      chk("rst_out_valid", 32'(q_if.out_valid), 32'd0);
      chk("rst_in_ready", 32'(q_if.in_ready), 32'd1);
      chk("rst_out_pc", q_if.out_pc, 32'h0);
      chk("rst_out_instr", q_if.out_instr, 32'h0);
      chk("rst_misaligned", 32'(q_if.out_misaligned), 32'd0);
      chk("rst_pc_plus4", q_if.out_pc_plus4, 32'h4);
      #4 rst = 1'b0;

      // Fill with out_ready = 0
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'(4 * k), 1'b0, 1'b0);
         edge1();
         chk("fill_count", 32'(q_if.count), 32'(k + 1));
         if (k == 0) chk("fill_lat_valid", 32'(q_if.out_valid), 32'd1);
      end
      chk("full_in_ready", 32'(q_if.in_ready), 32'd0);
      // Offered entry while full must be refused
      drive(1'b1, 32'h0000_0FF0, 1'b0, 1'b0);
      edge1();
      chk("full_hold_count", 32'(q_if.count), 32'd4);

      // Drain in order
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk("drain_pc", q_if.out_pc, 32'(4 * k));
         chk("drain_instr", q_if.out_instr, 32'hA000_0000 ^ 32'(4 * k));
         edge1();
      end
      chk("drain_count", 32'(q_if.count), 32'd0);
      chk("drain_out_valid", 32'(q_if.out_valid), 32'd0);

      // Wrap: ten entries streamed with simultaneous push/pop
      drive(1'b1, 32'h100, 1'b0, 1'b0);
      edge1();
      for (int k = 1; k < 10; k++) begin
         drive(1'b1, 32'h100 + 32'(4 * k), 1'b1, 1'b0);
         #1;
         chk("wrap_pc", q_if.out_pc, 32'h100 + 32'(4 * (k - 1)));
         edge1();
         chk("wrap_count", 32'(q_if.count), 32'd1);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      chk("wrap_last_pc", q_if.out_pc, 32'h124);
      edge1();
      chk("wrap_empty", 32'(q_if.count), 32'd0);

      // Flush with a concurrent push
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h300 + 32'(4 * k), 1'b0, 1'b0);
         edge1();
      end
      chk("pre_flush_count", 32'(q_if.count), 32'd3);
      drive(1'b1, 32'h200, 1'b0, 1'b1);
      #1;
      chk("flush_in_ready", 32'(q_if.in_ready), 32'd1);
      edge1();
      chk("flush_count", 32'(q_if.count), 32'd0);
      chk("flush_out_valid", 32'(q_if.out_valid), 32'd0);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      edge1();
      edge1();
      chk("flush_no_200", 32'(q_if.out_valid), 32'd0);

      // PC boundaries: wraparound of +4 and misalignment flag
      drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
      edge1();
      chk("bnd_pc", q_if.out_pc, 32'hFFFF_FFFC);
      chk("bnd_plus4_wrap", q_if.out_pc_plus4, 32'h0);
      chk("bnd_aligned", 32'(q_if.out_misaligned), 32'd0);
      drive(1'b1, 32'h2, 1'b1, 1'b0);
      edge1();
      chk("bnd_pc2", q_if.out_pc, 32'h2);
      chk("bnd_plus4_6", q_if.out_pc_plus4, 32'h6);
      chk("bnd_misaligned", 32'(q_if.out_misaligned), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      edge1();
      chk("bnd_empty", 32'(q_if.count), 32'd0);

      // Empty-queue latency / bypass
      drive(1'b1, 32'h40, 1'b1, 1'b0);
      #1;
`ifdef IFQ_BYPASS_EN
      chk("byp_valid", 32'(q_if.out_valid), 32'd1);
      chk("byp_pc", q_if.out_pc, 32'h40);
      edge1();
      chk("byp_count", 32'(q_if.count), 32'd0);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
`else
      chk("nobyp_valid_same", 32'(q_if.out_valid), 32'd0);
      edge1();
      chk("nobyp_valid_next", 32'(q_if.out_valid), 32'd1);
      chk("nobyp_pc", q_if.out_pc, 32'h40);
      chk("nobyp_count", 32'(q_if.count), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      edge1();
      chk("nobyp_drained", 32'(q_if.count), 32'd0);
`endif

      // Asynchronous reset with two entries queued
      drive(1'b1, 32'h500, 1'b0, 1'b0);
      edge1();
      drive(1'b1, 32'h504, 1'b0, 1'b0);
      edge1();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("arst_pre_count", 32'(q_if.count), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", 32'(q_if.count), 32'd0);
      chk("arst_out_valid", 32'(q_if.out_valid), 32'd0);
      chk("arst_out_pc", q_if.out_pc, 32'h0);
      chk("arst_pc_plus4", q_if.out_pc_plus4, 32'h4);
      #1 rst = 1'b0;
      #1;
      chk("arst_in_ready", 32'(q_if.in_ready), 32'd1);
      drive(1'b1, 32'h600, 1'b0, 1'b0);
      edge1();
      chk("post_rst_push_count", 32'(q_if.count), 32'd1);
      chk("post_rst_push_pc", q_if.out_pc, 32'h600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
